// File: rtl/fw_ctrl_pkg.sv
// Shared types, width defaults and sweep arithmetic for the fw control blocks.
package fw_ctrl_pkg;

   localparam int FW_W_DEF    = 7;
   localparam int DWELL_W_DEF = 24;

   // Widest fw any instantiating block may use; next_point works at this width.
   localparam int FW_MAX_W    = 16;

   typedef logic [FW_MAX_W-1:0] fw_word_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } sweep_state_t;

   // Next sweep point: step toward fw_end and clamp on it.
   // Direction comes from where the current point sits relative to fw_end.
   // One extra bit of headroom keeps the add/subtract from wrapping.
   function automatic fw_word_t next_point(input fw_word_t cur,
                                           input fw_word_t fw_end,
                                           input fw_word_t step);
      logic [FW_MAX_W:0] sum;
      logic [FW_MAX_W:0] diff;
      sum  = {1'b0, cur} + {1'b0, step};
      diff = {1'b0, cur} - {1'b0, step};
      if (cur < fw_end) begin
         next_point = (sum > {1'b0, fw_end}) ? fw_end : sum[FW_MAX_W-1:0];
      end else begin
         // A set top bit is a borrow: the step went below zero.
         next_point = (diff[FW_MAX_W] || (diff[FW_MAX_W-1:0] < fw_end)) ?
                      fw_end : diff[FW_MAX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that marks the end of a sweep point's dwell.
// Loaded with dwell_eff-1, it reads zero in the last cycle of the dwell.
module dwell_timer #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   // Count down from the loaded value and stop at zero.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments in clocked blocks, so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/fw_sweep_ctrl.sv
// Frequency-word sequencer: passes the manual fw through in IDLE and runs an
// automatic start->end sweep with per-point dwell in SWEEP.
module fw_sweep_ctrl
   import fw_ctrl_pkg::*;
#(
   parameter int FW_W    = FW_W_DEF,   // at most FW_MAX_W
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FW_W-1:0]    manual_fw,
   input  logic               sweep_start,
   input  logic               sweep_stop,
   input  logic [FW_W-1:0]    fw_start,
   input  logic [FW_W-1:0]    fw_end,
   input  logic [FW_W-1:0]    fw_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               loop_en,
   output logic [FW_W-1:0]    fw_out,
   output logic               fw_load,
   output logic               sweep_busy,
   output logic               sweep_done
);

   sweep_state_t        state_q, state_d;
   logic [FW_W-1:0]     manual_q;
   logic                manual_chg;

   // Configuration captured at sweep start.
   logic [FW_W-1:0]     start_q, end_q, step_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic                loop_q;
   logic                latch_cfg;

   logic [FW_W-1:0]     step_in_eff;
   logic [DWELL_W-1:0]  dwell_in_eff;

   logic [FW_W-1:0]     fw_d;
   logic                load_d, done_d;

   logic                tmr_load, tmr_expired;
   logic [DWELL_W-1:0]  tmr_val;

   fw_word_t            np_full;
   logic [FW_W-1:0]     np;
   logic                unused_np_hi;

   assign manual_chg   = (manual_fw != manual_q);
   assign step_in_eff  = (fw_step == '0) ? FW_W'(1)    : fw_step;
   assign dwell_in_eff = (dwell   == '0) ? DWELL_W'(1) : dwell;

   assign np_full      = next_point(fw_word_t'(fw_out), fw_word_t'(end_q),
                                    fw_word_t'(step_q));
   assign np           = np_full[FW_W-1:0];
   // Clamping on end_q keeps the upper bits zero; they are not needed.
   assign unused_np_hi = ^(np_full >> FW_W);

   dwell_timer #(.W(DWELL_W)) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and next output values.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      fw_d      = fw_out;
      load_d    = 1'b0;
      done_d    = 1'b0;
      latch_cfg = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = dwell_q - DWELL_W'(1);

      unique case (state_q)
         IDLE: begin
            // Stop wins over a simultaneous start; start wins over a manual change.
            if (sweep_start && !sweep_stop) begin
               state_d   = SWEEP;
               fw_d      = fw_start;
               load_d    = 1'b1;
               latch_cfg = 1'b1;
               tmr_load  = 1'b1;
               tmr_val   = dwell_in_eff - DWELL_W'(1);
            end else if (manual_chg) begin
               fw_d   = manual_fw;
               load_d = 1'b1;
            end
         end

         SWEEP: begin
            if (sweep_stop || manual_chg) begin
               // Abort: hand the datapath straight back to the manual fw.
               state_d = IDLE;
               fw_d    = manual_fw;
               load_d  = 1'b1;
            end else if (tmr_expired) begin
               if (fw_out == end_q) begin
                  if (loop_q) begin
                     fw_d     = start_q;
                     load_d   = 1'b1;
                     tmr_load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     fw_d    = manual_fw;
                     load_d  = 1'b1;
                     done_d  = 1'b1;
                  end
               end else begin
                  fw_d     = np;
                  load_d   = 1'b1;
                  tmr_load = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // Output registers and the manual-fw change detector.
   always_ff @(posedge clk) begin
      if (rst) begin
         fw_out     <= '0;
         fw_load    <= 1'b0;
         sweep_done <= 1'b0;
         manual_q   <= '0;
      end else begin
         fw_out     <= fw_d;
         fw_load    <= load_d;
         sweep_done <= done_d;
         manual_q   <= manual_fw;
      end
   end

   // Sweep configuration shadow, written only on sweep entry.
   always_ff @(posedge clk) begin
      // NOTE: no reset here; these are only read in SWEEP, which cannot be
      // reached without first writing them.
      if (latch_cfg) begin
         start_q <= fw_start;
         end_q   <= fw_end;
         step_q  <= step_in_eff;
         dwell_q <= dwell_in_eff;
         loop_q  <= loop_en;
      end
   end

   assign sweep_busy = (state_q == SWEEP);

endmodule

// File: tb/tb_fw_sweep_ctrl.sv
// Self-checking bench for fw_sweep_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a sequence-level reference model.
module tb_fw_sweep_ctrl;

   localparam int FW_W    = 7;
   localparam int DWELL_W = 24;

   logic               clk;
   logic               rst;
   logic [FW_W-1:0]    manual_fw;
   logic               sweep_start;
   logic               sweep_stop;
   logic [FW_W-1:0]    fw_start;
   logic [FW_W-1:0]    fw_end;
   logic [FW_W-1:0]    fw_step;
   logic [DWELL_W-1:0] dwell;
   logic               loop_en;
   logic [FW_W-1:0]    fw_out;
   logic               fw_load;
   logic               sweep_busy;
   logic               sweep_done;

   fw_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .manual_fw   (manual_fw),
      .sweep_start (sweep_start),
      .sweep_stop  (sweep_stop),
      .fw_start    (fw_start),
      .fw_end      (fw_end),
      .fw_step     (fw_step),
      .dwell       (dwell),
      .loop_en     (loop_en),
      .fw_out      (fw_out),
      .fw_load     (fw_load),
      .sweep_busy  (sweep_busy),
      .sweep_done  (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a sweep is expanded into a queue of per-cycle slots.
   typedef struct {
      int fw;
      bit ld;
   } slot_t;

   slot_t seq_q[$];
   int    m_fw, m_manual_q;
   bit    m_load, m_busy, m_done;
   int    c_start, c_end, c_step, c_dwell;
   bit    c_loop;

   // Observed event counters for the directed scenarios.
   int    busy_cnt, ld_cnt, done_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One pass of the sweep: every point held c_dwell cycles, load on its first.
   function automatic void fill_seq();
      int p = c_start;
      forever begin
         for (int k = 0; k < c_dwell; k++) seq_q.push_back('{fw: p, ld: (k == 0)});
         if (p == c_end) break;
         if (c_end > c_start) p = (p + c_step > c_end) ? c_end : p + c_step;
         else                 p = (p - c_step < c_end) ? c_end : p - c_step;
      end
   endfunction

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      slot_t s;
      bit    chg = (int'(manual_fw) != m_manual_q);
      if (rst) begin
         m_fw = 0; m_load = 0; m_busy = 0; m_done = 0;
         seq_q.delete();
      end else if (!m_busy) begin
         m_done = 0;
         if (sweep_start && !sweep_stop) begin
            c_start = fw_start;
            c_end   = fw_end;
            c_step  = (fw_step == 0) ? 1 : int'(fw_step);
            c_dwell = (dwell == 0) ? 1 : int'(dwell);
            c_loop  = loop_en;
            seq_q.delete();
            fill_seq();
            s = seq_q.pop_front();
            m_fw = s.fw; m_load = 1; m_busy = 1;
         end else if (chg) begin
            m_fw = manual_fw; m_load = 1;
         end else begin
            m_load = 0;
         end
      end else begin
         m_done = 0;
         if (sweep_stop || chg) begin
            m_busy = 0; m_fw = manual_fw; m_load = 1;
            seq_q.delete();
         end else begin
            if (seq_q.size() == 0 && c_loop) fill_seq();
            if (seq_q.size() == 0) begin
               m_busy = 0; m_done = 1; m_fw = manual_fw; m_load = 1;
            end else begin
               s = seq_q.pop_front();
               m_fw = s.fw; m_load = s.ld;
            end
         end
      end
      m_manual_q = rst ? 0 : int'(manual_fw);
   endtask

   // One clock: model, edge, compare, then drop the one-cycle pulses.
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("fw_out",     fw_out,     m_fw);
      check("fw_load",    fw_load,    m_load);
      check("sweep_busy", sweep_busy, m_busy);
      check("sweep_done", sweep_done, m_done);
      if (sweep_busy) busy_cnt++;
      if (fw_load && sweep_busy) ld_cnt++;
      if (sweep_done) done_cnt++;
      sweep_start = 1'b0;
      sweep_stop  = 1'b0;
   endtask

   task automatic clear_counts();
      busy_cnt = 0; ld_cnt = 0; done_cnt = 0;
   endtask

   task automatic set_cfg(input int s, input int e, input int st, input int dw, input bit lp);
      fw_start = FW_W'(s);
      fw_end   = FW_W'(e);
      fw_step  = FW_W'(st);
      dwell    = DWELL_W'(dw);
      loop_en  = lp;
   endtask

   // Start a sweep and run until it leaves SWEEP, within a cycle budget.
   task automatic run_sweep(input int max_cycles);
      clear_counts();
      sweep_start = 1'b1;
      tick();
      for (int i = 0; i < max_cycles && sweep_busy; i++) tick();
      if (sweep_busy) check("sweep_timeout", 1, 0);
   endtask

   initial begin
      rst = 1'b1; manual_fw = '0; sweep_start = 1'b0; sweep_stop = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      clear_counts();
      m_manual_q = 0;
      tick();
      tick();
      check("reset_fw_out", fw_out, 0);
      check("reset_busy", sweep_busy, 0);
      rst = 1'b0;
      tick();

      // Manual change 0 -> 12: one load one cycle later, never busy.
      manual_fw = 7'd12;
      tick();
      check("manual_fw_out", fw_out, 12);
      check("manual_load", fw_load, 1);
      tick();
      check("manual_load_once", fw_load, 0);

      // Upward sweep 10,14,18,20 with five cycles per point.
      set_cfg(10, 20, 4, 5, 0);
      run_sweep(200);
      check("up_loads", ld_cnt, 4);
      check("up_busy_cycles", busy_cnt, 20);
      check("up_done", done_cnt, 1);
      check("up_fw_after", fw_out, 12);
      tick();

      // Downward 100..90, step and dwell of zero behave as one.
      set_cfg(100, 90, 0, 0, 0);
      run_sweep(200);
      check("down_loads", ld_cnt, 11);
      check("down_busy_cycles", busy_cnt, 11);
      check("down_done", done_cnt, 1);

      // Looping 3,4,5 with dwell 2; stop midway through the second pass.
      set_cfg(3, 5, 1, 2, 1);
      clear_counts();
      sweep_start = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) tick();
      check("loop_mid_fw", fw_out, 4);
      sweep_stop = 1'b1;
      tick();
      check("loop_stop_busy", sweep_busy, 0);
      check("loop_stop_fw", fw_out, 12);
      check("loop_no_done", done_cnt, 0);

      // Manual change in the same cycle as a dwell expiry.
      set_cfg(10, 20, 4, 3, 0);
      sweep_start = 1'b1;
      tick();
      tick();
      tick();
      manual_fw = 7'd33;
      tick();
      check("preempt_fw", fw_out, 33);
      check("preempt_busy", sweep_busy, 0);

      // Start and stop together: no sweep.
      sweep_start = 1'b1;
      sweep_stop  = 1'b1;
      tick();
      check("start_stop_idle", sweep_busy, 0);

      // Start together with a manual change: sweep starts, no later abort.
      manual_fw   = 7'd40;
      sweep_start = 1'b1;
      tick();
      check("start_chg_fw", fw_out, 10);
      tick();
      check("start_chg_busy", sweep_busy, 1);

      // Reset mid-sweep.
      rst = 1'b1;
      tick();
      check("rst_mid_fw", fw_out, 0);
      check("rst_mid_done", sweep_done, 0);
      rst = 1'b0;
      tick();

      // Single point at the top of the range.
      set_cfg(127, 127, 127, 2, 0);
      run_sweep(50);
      check("top_loads", ld_cnt, 1);
      check("top_busy_cycles", busy_cnt, 2);
      check("top_done", done_cnt, 1);

      // Random traffic, including config changes while sweeping.
      for (int i = 0; i < 5000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 39) == 0) manual_fw = FW_W'($urandom_range(0, 127));
         sweep_start = ($urandom_range(0, 7) == 0);
         sweep_stop  = ($urandom_range(0, 59) == 0);
         set_cfg($urandom_range(0, 127), $urandom_range(0, 127),
                 $urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(0, 1));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
